// File: rtl/ctrl_seq_unit.sv
// ctrl_seq_unit: registered WISC-S15 decoder that sequences LW/SW memory waits and two-phase CALL/RET
//   clk, rst_n                      clock, asynchronous active-low reset
//   instr_valid, opcode, branch_cond instruction from IF/ID
//   hold, flush                     stall (freeze everything), squash (clear bundle, back to DECODE)
//   instr_ready                     fetch back-pressure
//   ex_valid .. reg_write           registered ID/EX control bundle, all zero when ex_valid=0
//   halt                            sticky ERR halt, cleared only by reset
module ctrl_seq_unit #(
  parameter int OP_W    = 4,
  parameter int COND_W  = 3,
  parameter int ALUOP_W = 3,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [OP_W-1:0]    opcode,
  input  logic [COND_W-1:0]  branch_cond,
  input  logic               hold,
  input  logic               flush,
  output logic               instr_ready,
  output logic               ex_valid,
  output logic               data_reg,
  output logic               call,
  output logic               ret,
  output logic [COND_W:0]    branch,
  output logic               mem_to_reg,
  output logic               reg_to_mem,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src,
  output logic               sign_ext,
  output logic               reg_write,
  output logic               halt
);
  localparam logic [2:0] DECODE = 3'd0, MEM_WAIT = 3'd1, CALL2 = 3'd2, RET2 = 3'd3, HALT = 3'd4;
  typedef struct packed {
    logic               ex_valid;
    logic               data_reg;
    logic               call;
    logic               ret;
    logic [COND_W:0]    branch;
    logic               mem_to_reg;
    logic               reg_to_mem;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               sign_ext;
    logic               reg_write;
  } bnd_t;
  logic [2:0] state_q, state_d;
  logic [3:0] mem_cnt_q, mem_cnt_d;
  bnd_t       bnd_q, bnd_d, dec, ph2;
  logic       halt_q, halt_d;
  logic [3:0] op4;
  logic       is_err, is_mem;
  assign op4    = opcode[3:0];
  // opcode bits above the 4-bit map make the instruction illegal
  assign is_err = (op4 == 4'hF) || ((opcode >> 4) != '0);
  assign is_mem = (op4 == 4'h8) || (op4 == 4'h9);
  always_comb begin
    dec = '0;
    dec.ex_valid = 1'b1;
    case (op4)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7: begin
        dec.alu_op    = ALUOP_W'(op4[2:0]);
        dec.reg_write = 1'b1;
      end
      4'h4: begin
        dec.alu_op    = ALUOP_W'(op4[2:0]);
        dec.alu_src   = 1'b1;
        dec.sign_ext  = 1'b1;
        dec.reg_write = 1'b1;
      end
      4'h8, 4'h9: begin
        dec.data_reg   = 1'b1;
        dec.mem_to_reg = (op4 == 4'h8);
        dec.reg_to_mem = (op4 == 4'h9);
        dec.reg_write  = (op4 == 4'h8);
        dec.alu_src    = 1'b1;
        dec.sign_ext   = 1'b1;
      end
      4'hA, 4'hB: begin
        dec.alu_op    = ALUOP_W'(op4[2:0]);
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      4'hC: begin
        dec.branch   = {1'b1, branch_cond};
        dec.alu_src  = 1'b1;
        dec.sign_ext = 1'b1;
      end
      4'hD: begin
        dec.call       = 1'b1;
        dec.reg_to_mem = 1'b1;
        dec.alu_op     = ALUOP_W'(1);
      end
      4'hE: begin
        dec.call       = 1'b1;
        dec.ret        = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      default: dec.ex_valid = 1'b0;
    endcase
  end
  // second CALL/RET cycle: unconditional jump, SP still selected for CALL
  always_comb begin
    ph2 = '0;
    ph2.ex_valid = 1'b1;
    ph2.branch   = '1;
    ph2.call     = (state_q == CALL2);
    ph2.ret      = (state_q == RET2);
  end
  assign instr_ready = (state_q == DECODE) && !hold && !halt_q;
  always_comb begin
    state_d   = state_q;
    mem_cnt_d = mem_cnt_q;
    bnd_d     = bnd_q;
    halt_d    = halt_q;
    if (state_q != HALT && flush) begin
      state_d   = DECODE;
      mem_cnt_d = '0;
      bnd_d     = '0;
    end else if (state_q != HALT && !hold) begin
      case (state_q)
        MEM_WAIT: begin
          mem_cnt_d = mem_cnt_q - 4'd1;
          state_d   = (mem_cnt_q == 4'd1) ? DECODE : MEM_WAIT;
        end
        CALL2, RET2: begin
          bnd_d   = ph2;
          state_d = DECODE;
        end
        default: begin
          bnd_d = '0;
          if (instr_valid && is_err) begin
            halt_d  = 1'b1;
            state_d = HALT;
          end else if (instr_valid) begin
            bnd_d     = dec;
            mem_cnt_d = is_mem ? 4'(MEM_LAT - 1) : '0;
            state_d   = (op4 == 4'hD) ? CALL2 :
                        (op4 == 4'hE) ? RET2 :
                        (is_mem && MEM_LAT > 1) ? MEM_WAIT : DECODE;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DECODE;
      mem_cnt_q <= '0;
      bnd_q     <= '0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_cnt_q <= mem_cnt_d;
      bnd_q     <= bnd_d;
      halt_q    <= halt_d;
    end
  end
  assign {ex_valid, data_reg, call, ret, branch, mem_to_reg, reg_to_mem,
          alu_op, alu_src, sign_ext, reg_write} = bnd_q;
  assign halt = halt_q;
endmodule

// File: doc/ctrl_seq_unit.md
Name: ctrl_seq_unit

Overview:
Parametrised, sequencing successor to the WISC-S15 combinational decoder. It decodes opcode/branch_cond into registered ID/EX control bundles and sequences multi-cycle instructions: LW/SW memory wait, and two-phase CALL/RET stack push/pop. It also handles pipeline hold, flush and halt-on-ERR. It sits between the IF/ID register and the EX stage and back-pressures fetch through instr_ready.

Parameters:
OP_W, 4, opcode width; the opcode map below uses the low 4 bits.
COND_W, 3, branch condition width.
ALUOP_W, 3, ALU control width; must be at least 3.
MEM_LAT, 2, cycles each LW/SW occupies EX (1..15).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
instr_valid  in  1  opcode/branch_cond valid from IF/ID
opcode  in  OP_W  instruction opcode
branch_cond  in  COND_W  branch condition field
hold  in  1  hazard-unit stall; freeze state and outputs
flush  in  1  branch-resolution squash
instr_ready  out  1  decoder accepts an instruction this cycle
ex_valid  out  1  control bundle valid this cycle
data_reg  out  1  select data-segment register as read_data_1
call  out  1  select stack pointer as read_data_1 (CALL/RET phases)
ret  out  1  return phase active
branch  out  COND_W+1  bit COND_W = branch/jump, low bits = condition
mem_to_reg  out  1  load
reg_to_mem  out  1  store
alu_op  out  ALUOP_W  ALU control
alu_src  out  1  1 = immediate operand
sign_ext  out  1  sign-extend immediate
reg_write  out  1  register-file write enable
halt  out  1  sticky ERR halt

Behaviour:
- Reset (rst_n low, async): state=DECODE, mem_cnt=0, every output 0 except instr_ready=1.
- instr_ready = (state==DECODE) & ~hold & ~halt. An instruction is accepted on a rising edge with instr_valid & instr_ready. Its bundle appears registered on the next cycle with ex_valid=1. Latency is 1 cycle.
- If ex_valid=0, every control output is 0 (bubble). Halt is the only exception.
- Decode (alu_op zero-extended to ALUOP_W):
  - ADD/SUB/NAND/XOR/SRA/SRL/SLL: alu_op=opcode[2:0], alu_src=0, reg_write=1.
  - INC: as above, plus alu_src=1, sign_ext=1.
  - LW: data_reg=1, mem_to_reg=1, alu_op=000, alu_src=1, sign_ext=1, reg_write=1.
  - SW: data_reg=1, reg_to_mem=1, alu_op=000, alu_src=1, sign_ext=1.
  - LHB/LLB: alu_op=opcode[2:0], alu_src=1, sign_ext=0, reg_write=1.
  - B: branch={1,branch_cond}, alu_src=1, sign_ext=1.
  - CALL phase 1: call=1, reg_to_mem=1, alu_op=001 (SP-1).
  - CALL phase 2: call=1, branch={1,all-ones}.
  - RET phase 1: call=1, ret=1, mem_to_reg=1, alu_op=000 (SP+1).
  - RET phase 2: ret=1, branch={1,all-ones}.
  - ERR (1111): ex_valid stays 0, halt=1.
- FSM states are DECODE, MEM_WAIT, CALL2, RET2, HALT.
  - DECODE to MEM_WAIT on an accepted LW/SW when MEM_LAT>1. mem_cnt loads MEM_LAT-1. The bundle is held for MEM_LAT cycles total. mem_cnt decrements each non-hold cycle. At mem_cnt==1 the FSM returns to DECODE, and instr_ready rises in the last bundle cycle.
  - DECODE to CALL2 or RET2 on an accepted CALL/RET. Phase 1 is output in the next cycle and phase 2 in the cycle after. Both cycles have ex_valid=1. The FSM then returns to DECODE.
  - DECODE to HALT on an accepted ERR. HALT is left only by reset. instr_valid, hold and flush are ignored there.
- hold=1: state, mem_cnt and all outputs are frozen. No acceptance.
- flush=1, not in HALT: ex_valid and all outputs clear next cycle. The FSM goes to DECODE and any instruction presented that cycle is discarded. This aborts MEM_WAIT and CALL/RET mid-sequence.
- flush and hold in the same cycle: flush wins.
- Opcodes with OP_W>4 upper bits nonzero decode as ERR.
- Reset mid-sequence returns the FSM immediately to reset values; no partial bundle is emitted.

Test Plan:
1. Reset, then ADD (0000) with cond 3'b101 -> next cycle ex_valid=1, alu_op=000, alu_src=0, reg_write=1, branch=4'b0000.
2. MEM_LAT=3, LW -> bundle (mem_to_reg=1, data_reg=1, sign_ext=1) held 3 cycles; instr_ready=0 for 2 cycles, 1 in the third.
3. CALL then ADD back-to-back -> cycle1 call=1, reg_to_mem=1, alu_op=001; cycle2 branch=4'b1111; ADD accepted only after cycle2.
4. RET, flush asserted during phase 1 -> phase 2 never appears; next cycle all outputs 0, instr_ready=1.
5. hold=1 for 2 cycles during SW MEM_WAIT (MEM_LAT=2) -> outputs frozen, SW bundle lasts 4 cycles in total.
6. ERR (1111) -> halt=1, ex_valid=0 stays through later ADD and flush; rst_n low mid-halt -> halt=0 and instr_ready=1 asynchronously.
